// File: rtl/shift_pulse_seq_if.sv
// Control and status bundle for shift_pulse_seq.
// The master drives the requests and the pacing tick; the slave returns the strobe and status.
interface shift_pulse_seq_if #(
  parameter int CNT_W = 4
);
  logic             load;
  logic             abort;
  logic             sample_en;
  logic             rshift;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] shift_count;
  logic [2:0]       st;

  modport master (
    output load, abort, sample_en,
    input  rshift, busy, done, shift_count, st
  );

  modport slave (
    input  load, abort, sample_en,
    output rshift, busy, done, shift_count, st
  );
endinterface

// File: rtl/shift_pulse_seq.sv
// Emits a train of NUM_SHIFTS one-cycle shift strobes, paced by sample_en, with
// an optional lead-in, inter-pulse gap, abort, done strobe and auto-reload.
module shift_pulse_seq #(
  parameter int NUM_SHIFTS   = 10,
  parameter int CNT_W        = 4,
  parameter int LEAD_SAMPLES = 0,
  parameter int GAP_SAMPLES  = 1,
  parameter int AUTO_RELOAD  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_pulse_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // A frame begins in LEAD only when there is a lead-in to swallow.
  localparam state_e           START_ST  = (LEAD_SAMPLES > 0) ? LEAD : SHIFT;
  localparam logic [3:0]       LEAD_LAST = 4'((LEAD_SAMPLES > 0) ? LEAD_SAMPLES - 1 : 0);
  localparam logic [3:0]       GAP_LAST  = 4'((GAP_SAMPLES  > 0) ? GAP_SAMPLES  - 1 : 0);
  localparam logic [CNT_W-1:0] NUM_C     = CNT_W'(NUM_SHIFTS);

  state_e           state_q, state_d;
  logic [3:0]       smp_q, smp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             rshift_c, done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    cnt_d    = cnt_q;
    rshift_c = 1'b0;
    done_c   = 1'b0;
    if (bus.abort) begin
      // Abort wins over load, sample_en and the done strobe.
      state_d = IDLE;
      smp_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_d = START_ST;
            smp_d   = '0;
            cnt_d   = '0;
          end
        end
        LEAD: begin
          if (bus.sample_en) begin
            if (smp_q == LEAD_LAST) begin
              state_d = SHIFT;
              smp_d   = '0;
            end else begin
              smp_d = smp_q + 4'd1;
            end
          end
        end
        SHIFT: begin
          if (bus.sample_en) begin
            rshift_c = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == NUM_C)   state_d = DONE;
            else if (GAP_SAMPLES > 0) state_d = GAP;
          end
        end
        GAP: begin
          if (bus.sample_en) begin
            if (smp_q == GAP_LAST) begin
              state_d = SHIFT;
              smp_d   = '0;
            end else begin
              smp_d = smp_q + 4'd1;
            end
          end
        end
        DONE: begin
          done_c = 1'b1;
          if (AUTO_RELOAD != 0) begin
            state_d = START_ST;
            smp_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          smp_d   = '0;
        end
      endcase
    end
  end

  assign bus.rshift      = rshift_c;
  assign bus.done        = done_c;
  assign bus.busy        = (state_q == LEAD) || (state_q == SHIFT) ||
                           (state_q == GAP)  || (state_q == DONE);
  assign bus.shift_count = cnt_q;
  assign bus.st          = state_q;

endmodule

// File: tb/tb_shift_pulse_seq.sv
// Scoreboard bench: three sequencer configurations driven one at a time against
// a tick-index reference model of the strobe train.
module tb_shift_pulse_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_pulse_seq_if #(.CNT_W(4)) if_a ();
  shift_pulse_seq_if #(.CNT_W(4)) if_b ();
  shift_pulse_seq_if #(.CNT_W(4)) if_c ();

  shift_pulse_seq u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  shift_pulse_seq #(.NUM_SHIFTS(4), .LEAD_SAMPLES(2), .GAP_SAMPLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  shift_pulse_seq #(.NUM_SHIFTS(3), .GAP_SAMPLES(1), .AUTO_RELOAD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  typedef struct {
    logic       rs;
    logic       dn;
    logic       bz;
    logic [3:0] cnt;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   sel = 0;
  int   pulses = 0, dones = 0;

  // Reference model: phase 0 idle, 1 running, 2 done; tk = sample ticks seen in frame.
  int   m_n = 10, m_lead = 0, m_gap = 1, m_auto = 0;
  int   m_ph = 0, m_tk = 0, m_ns = 0;
  logic [3:0] m_cnt = '0;

  logic       o_rs, o_dn, o_bz;
  logic [3:0] o_cnt;
  logic [2:0] o_st;

  always_comb begin
    o_rs = if_a.rshift; o_dn = if_a.done; o_bz = if_a.busy; o_cnt = if_a.shift_count; o_st = if_a.st;
    case (sel)
      1: begin o_rs = if_b.rshift; o_dn = if_b.done; o_bz = if_b.busy; o_cnt = if_b.shift_count; o_st = if_b.st; end
      2: begin o_rs = if_c.rshift; o_dn = if_c.done; o_bz = if_c.busy; o_cnt = if_c.shift_count; o_st = if_c.st; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic ab, input logic se);
    if_a.load = 1'b0; if_a.abort = 1'b0; if_a.sample_en = 1'b0;
    if_b.load = 1'b0; if_b.abort = 1'b0; if_b.sample_en = 1'b0;
    if_c.load = 1'b0; if_c.abort = 1'b0; if_c.sample_en = 1'b0;
    case (sel)
      0: begin if_a.load = ld; if_a.abort = ab; if_a.sample_en = se; end
      1: begin if_b.load = ld; if_b.abort = ab; if_b.sample_en = se; end
      default: begin if_c.load = ld; if_c.abort = ab; if_c.sample_en = se; end
    endcase
  endtask

  task automatic model_reset();
    m_ph = 0; m_tk = 0; m_ns = 0; m_cnt = '0;
  endtask

  task automatic set_cfg(input int s, input int n, input int lead, input int gap, input int aut);
    sel = s; m_n = n; m_lead = lead; m_gap = gap; m_auto = aut;
    model_reset();
  endtask

  // One cycle: drive at negedge, push expectation, sample 2 time units later, then advance model.
  task automatic step(input logic ld, input logic ab, input logic se);
    exp_t e;
    logic on_slot, strobe;
    @(negedge clk);
    drive(ld, ab, se);
    on_slot = (m_tk >= m_lead) && (((m_tk - m_lead) % (m_gap + 1)) == 0);
    strobe  = (m_ph == 1) && se && !ab && on_slot;
    e.rs  = strobe;
    e.dn  = (m_ph == 2) && !ab;
    e.bz  = (m_ph != 0);
    e.cnt = m_cnt;
    e.st  = (m_ph == 0) ? 3'd0 : (m_ph == 2) ? 3'd4 : (m_tk < m_lead) ? 3'd1 : on_slot ? 3'd2 : 3'd3;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk("rshift", o_rs, e.rs);
    chk("done", o_dn, e.dn);
    chk("busy", o_bz, e.bz);
    chk("shift_count", o_cnt, e.cnt);
    chk("st", o_st, e.st);
    pulses += int'(o_rs);
    dones  += int'(o_dn);
    if (ab) begin
      m_ph = 0; m_tk = 0; m_ns = 0; m_cnt = '0;
    end else begin
      case (m_ph)
        0: if (ld) begin m_ph = 1; m_tk = 0; m_ns = 0; m_cnt = '0; end
        1: if (se) begin
             if (strobe) begin
               m_ns++;
               m_cnt = 4'(m_ns);
               if (m_ns == m_n) m_ph = 2;
             end
             m_tk++;
           end
        default: begin
          if (m_auto != 0) begin m_ph = 1; m_tk = 0; m_ns = 0; m_cnt = '0; end
          else m_ph = 0;
        end
      endcase
    end
  endtask

  initial begin
    int guard;
    drive(1'b0, 1'b0, 1'b0);
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk("rst_busy", o_bz, 1'b0);
      chk("rst_st", o_st, 3'd0);
      chk("rst_cnt", o_cnt, 4'd0);
      chk("rst_done", o_dn, 1'b0);
    end
    #1 rst_n = 1'b1;

    // Defaults, continuous sample_en: 10 strobes, one done.
    set_cfg(0, 10, 0, 1, 0);
    pulses = 0; dones = 0;
    step(1, 0, 1);
    repeat (25) step(0, 0, 1);
    chk("t1_pulses", pulses, 10);
    chk("t1_dones", dones, 1);
    chk("t1_final_cnt", o_cnt, 4'd10);

    // Abort coincident with the sixth strobe slot.
    pulses = 0; dones = 0;
    step(1, 0, 1);
    guard = 0;
    while (!(m_ph == 1 && m_ns == 5 && ((m_tk - m_lead) % (m_gap + 1)) == 0) && guard < 100) begin
      step(0, 0, 1);
      guard++;
    end
    chk("t3_reached", int'(guard < 100), 1);
    step(0, 1, 1);
    chk("t3_abort_rshift", o_rs, 1'b0);
    step(0, 0, 1);
    chk("t3_idle_cnt", o_cnt, 4'd0);
    repeat (3) step(0, 0, 1);
    chk("t3_dones", dones, 0);
    chk("t3_pulses", pulses, 5);

    // load pulsed mid-frame is ignored; load right after done restarts cleanly.
    pulses = 0; dones = 0;
    step(1, 0, 1);
    for (int i = 0; i < 18; i++) step((i % 3) == 0, 0, 1);
    guard = 0;
    while (m_ph != 2 && guard < 20) begin step(0, 0, 1); guard++; end
    chk("t4_reached_done", m_ph, 2);
    step(0, 0, 1);
    step(1, 0, 1);
    chk("t4_held_cnt", o_cnt, 4'd10);
    step(0, 0, 0);
    chk("t4_restart_cnt", o_cnt, 4'd0);
    chk("t4_pulses", pulses, 10);
    chk("t4_dones", dones, 1);
    step(0, 1, 0);
    step(0, 0, 0);

    // Asynchronous reset between edges while in GAP.
    step(1, 0, 1);
    step(0, 0, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    #2;
    chk("t6_in_gap", o_st, 3'd3);
    chk("t6_cnt_before", o_cnt, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", o_bz, 1'b0);
    chk("t6_rshift", o_rs, 1'b0);
    chk("t6_done", o_dn, 1'b0);
    chk("t6_cnt", o_cnt, 4'd0);
    model_reset();
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (5) step(0, 0, 1);
    chk("t6_quiet", pulses, 0);

    // Lead-in of 2, no gap, 4 strobes, sample_en every 3rd cycle.
    set_cfg(1, 4, 2, 0, 0);
    pulses = 0; dones = 0;
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, (i % 3) == 2);
    chk("t2_pulses", pulses, 4);
    chk("t2_dones", dones, 1);
    chk("t2_final_cnt", o_cnt, 4'd4);

    // Auto-reload, 3 strobes per frame, continuous sample_en.
    set_cfg(2, 3, 0, 1, 1);
    pulses = 0; dones = 0;
    step(1, 0, 1);
    repeat (30) step(0, 0, 1);
    chk("t5_pulses", pulses, 15);
    chk("t5_dones", dones, 5);
    step(0, 1, 1);
    step(0, 0, 1);
    chk("t5_abort_idle", o_st, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
